pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Front-end stage of the multi-cycle core. It owns the program counter and the 2-bit stage counter that drives the control decoder.
- It consumes the decoder's jump/call/ret outputs and produces the next fetch address.
- It holds a small hardware return-address stack (RAS) for call/ret, plus run/halt sequencing with a done flag for the testbench.

Parameters:
- PC_W, 10, program counter / instruction address width
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
- START_PC, 0, address loaded on start

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution from START_PC (level, sampled in IDLE/HALTED)
- halt  in  1  current instruction is the halt/done opcode (from instruction ROM decode)
- jump  in  1  decoder: take branch/jump this instruction
- call  in  1  decoder: instruction is call (asserted with jump)
- ret  in  1  decoder: instruction is return (asserted with jump)
- target  in  PC_W  branch/call target from the jump LUT
- stage  out  2  current instruction stage: 00 fetch/decode, 01 execute, 10 writeback
- pc  out  PC_W  current instruction address to instruction ROM
- running  out  1  high while in RUN
- done  out  1  high in HALTED
- ras_ovf  out  1  sticky: push attempted while RAS full
- ras_unf  out  1  sticky: pop attempted while RAS empty

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=START_PC, stage=00, sp=0, RAS contents cleared, running=0, done=0, ras_ovf=0, ras_unf=0. Reset mid-instruction aborts immediately, with no partial PC/RAS update.
- FSM states IDLE, RUN, HALTED.
  - IDLE --start--> RUN. Next cycle: pc=START_PC, stage=00.
  - RUN --(stage==10 && halt)--> HALTED. pc holds the halt instruction address.
  - HALTED --start--> RUN. Restart clears pc, stage, sp, ras_ovf and ras_unf.
- Stage counter, in RUN only: 00->01->10->00, one step per clk. Each instruction takes exactly 3 cycles. stage==11 is never produced. Outside RUN, stage=00.
- Control inputs (jump/call/ret/halt/target) are sampled only on the rising edge that leaves stage 10. Values in stages 00/01 are ignored.
- Next-PC at end of stage 10, priority order:
  1. halt: pc holds; go to HALTED.
  2. jump && call: push pc+1 (mod 2^PC_W) to RAS; pc=target.
  3. jump && ret: pop RAS; pc=popped value.
  4. jump: pc=target.
  5. otherwise: pc=pc+1.
- If call and ret are both high, call wins and ret is ignored.
- PC arithmetic is unsigned PC_W bits. pc+1 at all-ones wraps to 0 with no flag.
- RAS is a LIFO with sp in range 0..RAS_DEPTH.
  - Push when sp==RAS_DEPTH: entry dropped, sp unchanged, ras_ovf<=1. The jump to target still occurs.
  - Pop when sp==0: ras_unf<=1, sp unchanged, pc=pc+1 (treated as not-taken).
  - Only one push or pop per instruction, so there is no simultaneous push/pop.
- The sticky flags clear only on reset or on restart from HALTED.
- Outputs are registered. pc and stage change only on clk edges, or asynchronously on reset.
- start while in RUN is ignored.

Decomposition:
- Shared package core_pkg holds:
  - stage_t enum (STG_FETCH=2'b00, STG_EXEC=2'b01, STG_WB=2'b10)
  - seq_state_t enum (IDLE, RUN, HALTED)
  - PC_W default constant
  - START_PC constant
- One sub-module: ras_stack. Parameterised LIFO with push/pop/din, dout, full/empty, and a clear input.
- pc_sequencer holds the FSM, stage counter and next-PC mux.

Test Plan:
- Reset then start, no jumps, halt at pc=3 -> stage sequence 00,01,10 repeats. pc=0,1,2,3 changes only on 10->00 edges. done=1 after the 12th RUN cycle. pc stays 3.
- At pc=5 jump=1, target=0x040 in stage 10 -> next pc=0x040. Same inputs held only during stage 01 -> pc=6 (ignored).
- call at pc=0x010 target=0x100, then ret at pc=0x105 -> pc=0x100, then 0x011. sp returns to 0. No flags.
- Five nested calls with RAS_DEPTH=4 -> fifth call still jumps to target, ras_ovf=1. Five rets -> first four return the correct addresses in LIFO order; fifth sets ras_unf=1 and pc=pc+1.
- pc=0x3FF with no jump -> pc wraps to 0x000. call at 0x3FF pushes 0x000.
- Assert rst_n=0 mid-stage 01 after two pushes -> pc=0, stage=00, sp=0, state IDLE immediately (without waiting for a clk edge). start then restarts cleanly.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and defaults for the multi-cycle core front end.
package core_pkg;

   typedef enum logic [1:0] {
      STG_FETCH = 2'b00,
      STG_EXEC  = 2'b01,
      STG_WB    = 2'b10
   } stage_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } seq_state_t;

   localparam int          CORE_PC_W     = 10;
   localparam int unsigned CORE_START_PC = 0;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO; push when full and pop when empty are ignored here,
// the caller raises the sticky flags.
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;

   logic [W-1:0]   mem [DEPTH];
   logic [SPW-1:0] sp;
   logic [SPW-1:0] sp_dec;

   assign sp_dec = sp - SPW'(1);
   assign full   = (sp == SPW'(DEPTH));
   assign empty  = (sp == '0);
   assign dout   = mem[sp_dec[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         sp <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !full) begin
         mem[sp[AW-1:0]] <= din;
         sp              <= sp + SPW'(1);
      end else if (pop && !empty) begin
         sp <= sp_dec;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, stage counter and run/halt sequencing for the multi-cycle core.
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   RUN    | stepping fetch/exec/wb, next-PC applied leaving wb
//   HALTED | halt retired, pc parked on the halt instruction, done high
module pc_sequencer
   import core_pkg::*;
#(
   parameter int          PC_W      = CORE_PC_W,
   parameter int          RAS_DEPTH = 4,
   parameter int unsigned START_PC  = CORE_START_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            halt,
   input  logic            jump,
   input  logic            call,
   input  logic            ret,
   input  logic [PC_W-1:0] target,
   output logic [1:0]      stage,
   output logic [PC_W-1:0] pc,
   output logic            running,
   output logic            done,
   output logic            ras_ovf,
   output logic            ras_unf
);
   seq_state_t      state;
   stage_t          stg;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] ras_top;
   logic            ras_full;
   logic            ras_empty;
   logic            retire;
   logic            do_push;
   logic            do_pop;
   logic            restart;

   assign pc_inc  = pc + PC_W'(1);
   assign retire  = (state == RUN) && (stg == STG_WB) && !halt;
   assign do_push = retire && jump && call;
   assign do_pop  = retire && jump && ret && !call;
   assign restart = (state == HALTED) && start;
   assign stage   = stg;

   ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (restart),
      .push  (do_push),
      .pop   (do_pop),
      .din   (pc_inc),
      .dout  (ras_top),
      .full  (ras_full),
      .empty (ras_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         stg     <= STG_FETCH;
         pc      <= PC_W'(START_PC);
         running <= 1'b0;
         done    <= 1'b0;
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  stg     <= STG_FETCH;
                  pc      <= PC_W'(START_PC);
                  running <= 1'b1;
               end
            end
            RUN: begin
               case (stg)
                  STG_FETCH: stg <= STG_EXEC;
                  STG_EXEC:  stg <= STG_WB;
                  default: begin
                     stg <= STG_FETCH;
                     if (halt) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        done    <= 1'b1;
                     end else if (do_push) begin
                        pc <= target;
                        if (ras_full) ras_ovf <= 1'b1;
                     end else if (do_pop) begin
                        // An empty-stack return falls through as not-taken.
                        if (ras_empty) begin
                           pc      <= pc_inc;
                           ras_unf <= 1'b1;
                        end else begin
                           pc <= ras_top;
                        end
                     end else if (jump) begin
                        pc <= target;
                     end else begin
                        pc <= pc_inc;
                     end
                  end
               endcase
            end
            default: begin
               if (restart) begin
                  state   <= RUN;
                  stg     <= STG_FETCH;
                  pc      <= PC_W'(START_PC);
                  running <= 1'b1;
                  done    <= 1'b0;
                  ras_ovf <= 1'b0;
                  ras_unf <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reference model of pc/RAS/flags feeds an
// expected-pc queue that is drained after each instruction retires.
module tb_pc_sequencer;
   localparam int PC_W  = 10;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            halt = 1'b0;
   logic            jump = 1'b0;
   logic            call = 1'b0;
   logic            ret = 1'b0;
   logic [PC_W-1:0] target = '0;
   logic [1:0]      stage;
   logic [PC_W-1:0] pc;
   logic            running;
   logic            done;
   logic            ras_ovf;
   logic            ras_unf;

   pc_sequencer #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .START_PC(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .jump(jump),
      .call(call), .ret(ret), .target(target), .stage(stage), .pc(pc),
      .running(running), .done(done), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   int              n_cmp = 0;
   int              n_mis = 0;
   logic [PC_W-1:0] sb_q [$];
   logic [PC_W-1:0] m_ras [$];
   logic [PC_W-1:0] m_pc = '0;
   logic            m_ovf = 1'b0;
   logic            m_unf = 1'b0;
   logic            m_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic h, j, c, r, input logic [PC_W-1:0] t);
      halt = h; jump = j; call = c; ret = r; target = t;
   endtask

   task automatic model(input logic h, j, c, r, input logic [PC_W-1:0] t);
      if (h) begin
         m_done = 1'b1;
      end else if (j && c) begin
         if (m_ras.size() == DEPTH) m_ovf = 1'b1;
         else m_ras.push_back(m_pc + PC_W'(1));
         m_pc = t;
      end else if (j && r) begin
         if (m_ras.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = m_pc + PC_W'(1);
         end else begin
            m_pc = m_ras.pop_back();
         end
      end else if (j) begin
         m_pc = t;
      end else begin
         m_pc = m_pc + PC_W'(1);
      end
   endtask

   // One instruction; with early=1 the controls are shown only during exec.
   task automatic step(input logic h, j, c, r, input logic [PC_W-1:0] t, input bit early = 1'b0);
      logic [PC_W-1:0] cur;
      logic [PC_W-1:0] exp_pc;
      cur = m_pc;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("stage_seq", stage, s);
         chk("pc_hold", pc, cur);
         if (s == 1 && early) drive(h, j, c, r, t);
         if (s == 2) begin
            if (early) begin
               drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
               model(1'b0, 1'b0, 1'b0, 1'b0, '0);
            end else begin
               drive(h, j, c, r, t);
               model(h, j, c, r, t);
            end
            sb_q.push_back(m_pc);
         end
      end
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      exp_pc = sb_q.pop_front();
      chk("pc_next", pc, exp_pc);
      chk("stage_after", stage, 0);
      chk("ras_ovf", ras_ovf, m_ovf);
      chk("ras_unf", ras_unf, m_unf);
      chk("done", done, m_done);
      chk("running", running, !m_done);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0; m_done = 1'b0;
      m_ras.delete();
      chk("start_pc", pc, 0);
      chk("start_stage", stage, 0);
      chk("start_running", running, 1);
      chk("start_done", done, 0);
      chk("start_ovf", ras_ovf, 0);
      chk("start_unf", ras_unf, 0);
   endtask

   initial begin
      #12;
      chk("rst_pc", pc, 0);
      chk("rst_stage", stage, 0);
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_flags", {ras_ovf, ras_unf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_stage", stage, 0);
      chk("idle_running", running, 0);

      // Straight-line run halting at pc=3 after 12 run cycles.
      do_start();
      repeat (3) step(0, 0, 0, 0, '0);
      step(1, 0, 0, 0, 10'h3AA);
      repeat (3) @(negedge clk);
      chk("halt_pc_hold", pc, 3);
      chk("halt_stage", stage, 0);
      chk("halt_done", done, 1);
      @(negedge clk);
      start = 1'b0;

      // Restart; jump taken at wb, ignored when only shown during exec.
      do_start();
      repeat (5) step(0, 0, 0, 0, '0);
      step(0, 1, 0, 0, 10'h040);
      step(0, 1, 0, 0, 10'h123, 1'b1);
      step(0, 1, 0, 0, 10'h010);

      // Simple call/ret pair.
      step(0, 1, 1, 0, 10'h100);
      repeat (5) step(0, 0, 0, 0, '0);
      step(0, 1, 0, 1, 10'h2EE);

      // Five nested calls overflow, five returns underflow.
      step(0, 1, 1, 0, 10'h200);
      step(0, 1, 1, 0, 10'h210);
      step(0, 1, 1, 0, 10'h220);
      step(0, 1, 1, 0, 10'h230);
      step(0, 1, 1, 0, 10'h240);
      repeat (5) step(0, 1, 0, 1, 10'h155);

      // PC wrap, call from the top address, call beats ret.
      step(0, 1, 0, 0, 10'h3FF);
      step(0, 0, 0, 0, '0);
      step(0, 1, 0, 0, 10'h3FF);
      step(0, 1, 1, 0, 10'h050);
      step(0, 1, 1, 1, 10'h060);
      step(0, 1, 0, 1, '0);
      step(0, 1, 0, 1, '0);
      step(1, 0, 0, 0, '0);

      // Restart from HALTED clears sticky flags and stack.
      do_start();
      step(0, 1, 0, 1, '0);
      step(0, 1, 1, 0, 10'h080);
      step(0, 1, 1, 0, 10'h090);

      // Async reset during exec of the next instruction.
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_stage", stage, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_pc", pc, 0);
      chk("arst_stage", stage, 0);
      chk("arst_running", running, 0);
      chk("arst_flags", {done, ras_ovf, ras_unf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      step(0, 1, 0, 1, '0);
      step(0, 0, 0, 0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
